// File: rtl/sdram_bank_cmd_issuer.sv
// sdram_bank_cmd_issuer
// Per-request command sequencer sitting in front of the SDRAM bank-state
// tracker. One column request is taken at a time. The issuer looks at the
// tracker's view of the target bank, emits the precharge / activate pulses
// needed to open the right row, then offers the column command downstream.
// Row-hit / row-miss / bank-empty statistics are kept in saturating counters.
//
// Handshakes (req_* and cmd_*) are valid/ready. A transfer happens on a rising
// clk edge where valid and ready are both 1. The side holding valid keeps its
// payload stable until that edge. Ready may depend on state but never on valid.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_bank/row/col/write   request payload
//   active_row_in            open row per bank (bank k at bits k*ROW_WIDTH +: ROW_WIDTH)
//   active_bank, blocked     per-bank open / busy flags from the tracker
//   precharge, activate      one-hot, one-cycle pulses to the tracker
//   row_address              row for activate, zero when no activate is issued
//   cmd_valid/cmd_ready      column command handshake
//   cmd_write/bank/col       column command payload
//   hit/miss/empty_count     saturating statistics
module sdram_bank_cmd_issuer #(
  parameter int ROW_WIDTH       = 14,
  parameter int COL_WIDTH       = 10,
  parameter int NUM_GROUPS      = 2,
  parameter int BANKS_PER_GROUP = 4,
  parameter int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
  parameter int BANK_IDX_W      = $clog2(BANKS),
  parameter int CLOSE_PAGE      = 0,
  parameter int STAT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [BANK_IDX_W-1:0]      req_bank,
  input  logic [ROW_WIDTH-1:0]       req_row,
  input  logic [COL_WIDTH-1:0]       req_col,
  input  logic                       req_write,
  input  logic [BANKS*ROW_WIDTH-1:0] active_row_in,
  input  logic [BANKS-1:0]           active_bank,
  input  logic [BANKS-1:0]           blocked,
  output logic [BANKS-1:0]           precharge,
  output logic [BANKS-1:0]           activate,
  output logic [ROW_WIDTH-1:0]       row_address,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic                       cmd_write,
  output logic [BANK_IDX_W-1:0]      cmd_bank,
  output logic [COL_WIDTH-1:0]       cmd_col,
  output logic [STAT_W-1:0]          hit_count,
  output logic [STAT_W-1:0]          miss_count,
  output logic [STAT_W-1:0]          empty_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_PRE,
    S_WAIT_PRE,
    S_ACT,
    S_WAIT_ACT,
    S_CMD,
    S_CLOSE,
    S_WAIT_CLOSE
  } state_t;

  localparam logic [STAT_W-1:0] STAT_ONE = 1;
  localparam logic [BANKS-1:0]  SEL_ONE  = 1;

  state_t state_q, state_d;

  logic [BANK_IDX_W-1:0] lat_bank;
  logic [ROW_WIDTH-1:0]  lat_row;
  logic [COL_WIDTH-1:0]  lat_col;
  logic                  lat_write;

  logic                  bank_blocked;
  logic                  bank_open;
  logic [ROW_WIDTH-1:0]  open_row;
  logic [BANKS-1:0]      bank_sel;
  logic                  hit_inc, miss_inc, empty_inc;

  assign bank_blocked = blocked[lat_bank];
  assign bank_open    = active_bank[lat_bank];
  assign open_row     = active_row_in[int'(lat_bank)*ROW_WIDTH +: ROW_WIDTH];
  assign bank_sel     = SEL_ONE << lat_bank;

  // Pulses and command fields come only from the registered state and the
  // latched request, so tracker inputs never reach the pulse outputs in the
  // same cycle.
  assign req_ready   = (state_q == S_IDLE);
  assign precharge   = (state_q == S_PRE || state_q == S_CLOSE) ? bank_sel : '0;
  assign activate    = (state_q == S_ACT) ? bank_sel : '0;
  assign row_address = (state_q == S_ACT) ? lat_row : '0;
  assign cmd_valid   = (state_q == S_CMD);
  assign cmd_write   = lat_write;
  assign cmd_bank    = lat_bank;
  assign cmd_col     = lat_col;

  always_comb begin
    state_d   = state_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    empty_inc = 1'b0;
    case (state_q)
      S_IDLE:       if (req_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!bank_blocked) begin
          if (bank_open && open_row == lat_row) begin
            hit_inc = 1'b1;
            state_d = S_CMD;
          end else if (bank_open) begin
            miss_inc = 1'b1;
            state_d  = S_PRE;
          end else begin
            empty_inc = 1'b1;
            state_d   = S_ACT;
          end
        end
      end
      S_PRE:        state_d = S_WAIT_PRE;
      // The tracker raises blocked on the edge that samples the pulse, so
      // the first wait cycle already sees it high.
      S_WAIT_PRE:   if (!bank_blocked) state_d = S_ACT;
      S_ACT:        state_d = S_WAIT_ACT;
      S_WAIT_ACT:   if (!bank_blocked) state_d = S_CMD;
      S_CMD: begin
        if (cmd_ready) state_d = (CLOSE_PAGE != 0) ? S_CLOSE : S_IDLE;
      end
      S_CLOSE:      state_d = S_WAIT_CLOSE;
      S_WAIT_CLOSE: if (!bank_blocked) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_write <= 1'b0;
    end else if (state_q == S_IDLE && req_valid) begin
      lat_bank  <= req_bank;
      lat_row   <= req_row;
      lat_col   <= req_col;
      lat_write <= req_write;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      empty_count <= '0;
    end else begin
      if (hit_inc && hit_count != '1)     hit_count   <= hit_count + STAT_ONE;
      if (miss_inc && miss_count != '1)   miss_count  <= miss_count + STAT_ONE;
      if (empty_inc && empty_count != '1) empty_count <= empty_count + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_sdram_bank_cmd_issuer.sv
// Bench for sdram_bank_cmd_issuer. Three instances are driven:
//   0: open page, 16-bit counters   1: close page   2: open page, 2-bit counters
// A behavioural tracker (ACT latency 8, PRE latency 5) answers each instance.
// A reference model predicts, per accepted request, the ordered list of
// pulses and column commands from the bank's open/closed row history.
module tb_sdram_bank_cmd_issuer;
  localparam int RW = 14, CW = 10, NB = 8, NI = 3, EW = 32;
  localparam int ACT_LAT = 8, PRE_LAT = 5;
  localparam logic [1:0] K_PRE = 2'd1, K_ACT = 2'd2, K_CMD = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid [NI];
  logic            req_ready [NI];
  logic            req_write [NI];
  logic [2:0]      req_bank [NI];
  logic [RW-1:0]   req_row [NI];
  logic [CW-1:0]   req_col [NI];
  logic [NB*RW-1:0] active_row_in [NI];
  logic [NB-1:0]   active_bank [NI];
  logic [NB-1:0]   blocked [NI];
  logic [NB-1:0]   force_blk [NI];
  logic [NB-1:0]   precharge [NI];
  logic [NB-1:0]   activate [NI];
  logic [RW-1:0]   row_address [NI];
  logic            cmd_valid [NI];
  logic            cmd_ready [NI];
  logic            cmd_write [NI];
  logic [2:0]      cmd_bank [NI];
  logic [CW-1:0]   cmd_col [NI];
  logic [15:0]     hit_cnt [NI];
  logic [15:0]     miss_cnt [NI];
  logic [15:0]     empty_cnt [NI];
  int              rdy_mode [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int SW = (g == 0) ? 16 : 2;
    localparam int CP = (g == 1) ? 1 : 0;
    logic [SW-1:0] hc, mc, ec;
    sdram_bank_cmd_issuer #(
      .ROW_WIDTH(RW), .COL_WIDTH(CW), .NUM_GROUPS(2), .BANKS_PER_GROUP(4),
      .CLOSE_PAGE(CP), .STAT_W(SW)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_bank(req_bank[g]), .req_row(req_row[g]), .req_col(req_col[g]),
      .req_write(req_write[g]),
      .active_row_in(active_row_in[g]), .active_bank(active_bank[g]),
      .blocked(blocked[g]),
      .precharge(precharge[g]), .activate(activate[g]),
      .row_address(row_address[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_write(cmd_write[g]), .cmd_bank(cmd_bank[g]), .cmd_col(cmd_col[g]),
      .hit_count(hc), .miss_count(mc), .empty_count(ec)
    );
    assign hit_cnt[g]   = 16'(hc);
    assign miss_cnt[g]  = 16'(mc);
    assign empty_cnt[g] = 16'(ec);
  end

  // ---------------- tracker model ----------------
  int            trk_cnt [NI][NB];
  logic          trk_open [NI][NB];
  logic [RW-1:0] trk_row [NI][NB];

  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      for (int k = 0; k < NB; k++) begin
        if (rst) begin
          trk_cnt[d][k]  <= 0;
          trk_open[d][k] <= 1'b0;
          trk_row[d][k]  <= '0;
        end else if (activate[d][k]) begin
          trk_cnt[d][k]  <= ACT_LAT;
          trk_open[d][k] <= 1'b1;
          trk_row[d][k]  <= row_address[d];
        end else if (precharge[d][k]) begin
          trk_cnt[d][k]  <= PRE_LAT;
          trk_open[d][k] <= 1'b0;
        end else if (trk_cnt[d][k] != 0) begin
          trk_cnt[d][k]  <= trk_cnt[d][k] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NI; d++) begin
      blocked[d]       = '0;
      active_bank[d]   = '0;
      active_row_in[d] = '0;
      for (int k = 0; k < NB; k++) begin
        blocked[d][k]     = (trk_cnt[d][k] != 0) || force_blk[d][k];
        active_bank[d][k] = trk_open[d][k];
        active_row_in[d][k*RW +: RW] = trk_row[d][k];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  bit            m_open [NI][NB];
  bit [RW-1:0]   m_row [NI][NB];
  int            m_hit [NI];
  int            m_miss [NI];
  int            m_empty [NI];
  bit            m_last_hit [NI];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int stat_max(int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  function automatic logic [EW-1:0] mk_evt(int d, logic [1:0] kind, int bank,
                                           logic [RW-1:0] row, logic [CW-1:0] col, logic wr);
    logic [1:0] dd;
    logic [2:0] bb;
    dd = d[1:0];
    bb = bank[2:0];
    return {dd, kind, bb, row, col, wr};
  endfunction

  function automatic int bank_of(logic [NB-1:0] v);
    for (int k = 0; k < NB; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_accept(int d);
    int b;
    logic [RW-1:0] r;
    b = int'(req_bank[d]);
    r = req_row[d];
    m_last_hit[d] = 1'b0;
    if (m_open[d][b] && m_row[d][b] == r) begin
      m_last_hit[d] = 1'b1;
      if (m_hit[d] < stat_max(d)) m_hit[d]++;
    end else if (m_open[d][b]) begin
      if (m_miss[d] < stat_max(d)) m_miss[d]++;
      exp_q.push_back(mk_evt(d, K_PRE, b, '0, '0, 1'b0));
      exp_q.push_back(mk_evt(d, K_ACT, b, r, '0, 1'b0));
    end else begin
      if (m_empty[d] < stat_max(d)) m_empty[d]++;
      exp_q.push_back(mk_evt(d, K_ACT, b, r, '0, 1'b0));
    end
    exp_q.push_back(mk_evt(d, K_CMD, b, '0, req_col[d], req_write[d]));
    if (d == 1) begin
      exp_q.push_back(mk_evt(d, K_PRE, b, '0, '0, 1'b0));
      m_open[d][b] = 1'b0;
    end else begin
      m_open[d][b] = 1'b1;
      m_row[d][b]  = r;
    end
  endtask

  task automatic observe_evt(logic [EW-1:0] e);
    if (exp_q.size() == 0) check("unexpected_evt", e, 0);
    else check("evt_order", e, exp_q.pop_front());
  endtask

  task automatic observe_pulse(int d, logic [1:0] kind, logic [NB-1:0] vec, logic [RW-1:0] row);
    int b;
    b = bank_of(vec);
    check("pulse_onehot", $countones(vec), 1);
    check("pulse_while_blocked", blocked[d][b], 0);
    check("pulse_bank_state", trk_open[d][b], (kind == K_PRE) ? 1 : 0);
    observe_evt(mk_evt(d, kind, b, row, '0, 1'b0));
  endtask

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        for (int d = 0; d < NI; d++) begin
          m_hit[d] = 0; m_miss[d] = 0; m_empty[d] = 0; m_last_hit[d] = 1'b0;
          for (int k = 0; k < NB; k++) begin
            m_open[d][k] = 1'b0;
            m_row[d][k]  = '0;
          end
        end
      end else begin
        for (int d = 0; d < NI; d++) begin
          if (req_valid[d] && req_ready[d]) model_accept(d);
          if (activate[d] == 0) check("row_addr_idle", row_address[d], 0);
          if (precharge[d] != 0 && activate[d] != 0) check("pre_act_overlap", activate[d], 0);
          if (precharge[d] != 0) observe_pulse(d, K_PRE, precharge[d], '0);
          if (activate[d] != 0) observe_pulse(d, K_ACT, activate[d], row_address[d]);
          if (cmd_valid[d] && cmd_ready[d])
            observe_evt(mk_evt(d, K_CMD, int'(cmd_bank[d]), '0, cmd_col[d], cmd_write[d]));
        end
      end
    end
  end

  // cmd_ready policy: 0 random, 1 always ready, 2 held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NI; d++) begin
        case (rdy_mode[d])
          0:       cmd_ready[d] = ($urandom_range(0, 2) != 0);
          1:       cmd_ready[d] = 1'b1;
          default: cmd_ready[d] = 1'b0;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(int d, int b, int r, int c, bit w);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_bank[d]  = 3'(b);
    req_row[d]   = RW'(r);
    req_col[d]   = CW'(c);
    req_write[d] = w;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[d] && !rst) ok = 1'b1;
    end
    check("req_accept", ok, 1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  // Called at accept edge + #1; counts edges from the accept edge.
  task automatic wait_cmd(int d, bit chk_lat);
    int lat;
    lat = 1;
    while (!cmd_valid[d] && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("cmd_valid_seen", cmd_valid[d], 1);
    if (chk_lat && m_last_hit[d]) check("hit_latency", lat, 2);
  endtask

  task automatic wait_idle(int d);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[d]) break;
    end
    check("req_ready_return", req_ready[d], 1);
    check("queue_drained", exp_q.size(), 0);
    check("hit_count", hit_cnt[d], m_hit[d]);
    check("miss_count", miss_cnt[d], m_miss[d]);
    check("empty_count", empty_cnt[d], m_empty[d]);
  endtask

  task automatic do_req(int d, int b, int r, int c, bit w);
    start_req(d, b, r, c, w);
    wait_cmd(d, 1'b1);
    wait_idle(d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] s_col;
    logic [2:0]    s_bank;
    logic          s_wr;
    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_bank[d] = '0;
      req_row[d] = '0; req_col[d] = '0; cmd_ready[d] = 1'b0;
      force_blk[d] = '0; rdy_mode[d] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_cmd_valid", cmd_valid[d], 0);
      check("rst_precharge", precharge[d], 0);
      check("rst_activate", activate[d], 0);
      check("rst_counters", {hit_cnt[d], miss_cnt[d], empty_cnt[d]}, 0);
    end
    rst = 1'b0;

    // empty bank, hit, miss on instance 0
    rdy_mode[0] = 0;
    do_req(0, 3, 'h1A2, 5, 1'b0);
    check("t_empty_count", empty_cnt[0], 1);
    rdy_mode[0] = 1;
    do_req(0, 3, 'h1A2, 9, 1'b1);
    check("t_hit_count", hit_cnt[0], 1);
    do_req(0, 3, 'h0F0, 7, 1'b0);
    check("t_miss_count", miss_cnt[0], 1);

    // backpressure: command held with cmd_ready low
    rdy_mode[0] = 2;
    start_req(0, 5, 'h7, 'h3FF, 1'b1);
    wait_cmd(0, 1'b0);
    check("stall_col", cmd_col[0], 'h3FF);
    s_col = cmd_col[0]; s_bank = cmd_bank[0]; s_wr = cmd_write[0];
    repeat (10) begin
      @(posedge clk);
      #1;
      check("stall_fields", {cmd_valid[0], cmd_bank[0], cmd_col[0], cmd_write[0]},
            {1'b1, s_bank, s_col, s_wr});
      check("stall_req_ready", req_ready[0], 0);
    end
    rdy_mode[0] = 1;
    wait_idle(0);

    // request to a bank the tracker holds blocked
    @(posedge clk);
    #1;
    force_blk[0][6] = 1'b1;
    start_req(0, 6, 'h22, 'h11, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("blk_quiet", {precharge[0], activate[0], cmd_valid[0]}, 0);
    end
    force_blk[0][6] = 1'b0;
    wait_cmd(0, 1'b0);
    wait_idle(0);

    // close page on instance 1
    start_req(1, 0, 'h33, 4, 1'b0);
    wait_cmd(1, 1'b1);
    wait_idle(1);
    check("close_unblocked", blocked[1][0], 0);

    // reset together with a request: not accepted
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_bank[0] = 3'd2; req_row[0] = RW'(5); req_col[0] = CW'(1); req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstreq_cmd_valid", cmd_valid[0], 0);
    check("rstreq_empty", empty_cnt[0], 0);
    check("rstreq_ready", req_ready[0], 1);

    // reset while waiting for activate latency
    start_req(0, 1, 'h55, 3, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (activate[0] != 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_outputs", {precharge[0], activate[0], row_address[0], cmd_valid[0]}, 0);
    check("midrst_cmd_fields", {cmd_bank[0], cmd_col[0], cmd_write[0]}, 0);
    check("midrst_req_ready", req_ready[0], 1);
    check("midrst_counters", {hit_cnt[0], miss_cnt[0], empty_cnt[0]}, 0);
    repeat (15) @(posedge clk);

    // counter saturation on instance 2 (2-bit counters)
    do_req(2, 2, 9, 1, 1'b0);
    for (int i = 0; i < 5; i++) do_req(2, 2, 9, 10 + i, 1'b1);
    check("sat_hit", hit_cnt[2], 3);
    check("sat_empty", empty_cnt[2], 1);

    // randomized traffic
    for (int d = 0; d < NI; d++) begin
      for (int n = 0; n < 20; n++) begin
        int b, r, c;
        bit w, blk;
        rdy_mode[d] = $urandom_range(0, 1);
        b   = (d == 2) ? $urandom_range(0, 1) : $urandom_range(0, NB - 1);
        r   = $urandom_range(0, 2);
        c   = $urandom_range(0, 1023);
        w   = 1'($urandom_range(0, 1));
        blk = ($urandom_range(0, 4) == 0);
        if (blk) begin
          @(posedge clk);
          #1;
          force_blk[d][b] = 1'b1;
        end
        start_req(d, b, r, c, w);
        if (blk) begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
          force_blk[d][b] = 1'b0;
        end
        wait_cmd(d, !blk);
        wait_idle(d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_bank_cmd_issuer.md
Name: sdram_bank_cmd_issuer

Overview:
- Per-request command sequencer placed directly upstream of the SDRAM bank-state tracker.
- Accepts one column request at a time (bank, row, column, read/write).
- Inspects the tracker's per-bank active/blocked/open-row state and drives its one-cycle precharge/activate pulses and row address in the legal order.
- Hands the final column command to the data path with a valid/ready handshake; keeps row-hit/miss/empty statistics.

Parameters:
- ROW_WIDTH, 14, row address bits.
- COL_WIDTH, 10, column address bits.
- NUM_GROUPS, 2, bank groups.
- BANKS_PER_GROUP, 4, banks per group.
- BANKS, NUM_GROUPS*BANKS_PER_GROUP, total banks.
- BANK_IDX_W, $clog2(BANKS), bank index width.
- CLOSE_PAGE, 0, 1 = auto-precharge the bank after each column command; 0 = leave row open.
- STAT_W, 16, width of the saturating statistic counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_bank  in  BANK_IDX_W  target bank
- req_row  in  ROW_WIDTH  target row
- req_col  in  COL_WIDTH  target column
- req_write  in  1  1 = write, 0 = read
- active_row_in  in  BANKS*ROW_WIDTH  open row per bank, from tracker
- active_bank  in  BANKS  bank has an open row, from tracker
- blocked  in  BANKS  bank busy with activate/precharge latency, from tracker
- precharge  out  BANKS  one-hot one-cycle precharge pulse to tracker
- activate  out  BANKS  one-hot one-cycle activate pulse to tracker
- row_address  out  ROW_WIDTH  row for activate; valid while activate is high
- cmd_valid  out  1  column command pending
- cmd_ready  in  1  data path accepts column command
- cmd_write  out  1  command type
- cmd_bank  out  BANK_IDX_W  command bank
- cmd_col  out  COL_WIDTH  command column
- hit_count, miss_count, empty_count  out  STAT_W each  saturating statistics

Behaviour:
- Reset (synchronous, on any rising clk with rst = 1, including mid-sequence):
  - state = IDLE; all pulses, cmd_valid and counters = 0; req_ready = 1.
  - Latched request discarded.
- Outputs are decoded from the registered state and latched request only; no combinational path from blocked or active_bank to precharge or activate.
- IDLE: req_ready = 1. On handshake, latch bank/row/col/write and go to CHECK. req_ready = 0 in every other state, so there is one request in flight.
- CHECK (bank b = latched bank):
  - blocked[b] = 1 → stay.
  - else active_bank[b] & active_row_in[b] == row → hit_count++, go to CMD.
  - else active_bank[b] → miss_count++, go to PRE.
  - else → empty_count++, go to ACT.
- PRE: precharge[b] = 1 for exactly this one cycle → WAIT_PRE.
- WAIT_PRE: stay while blocked[b] = 1; when 0 → ACT. The tracker sets blocked on the edge that samples the pulse, so blocked is already 1 on the first WAIT cycle and no extra settle cycle is needed.
- ACT: activate[b] = 1 and row_address = latched row for exactly one cycle → WAIT_ACT.
- WAIT_ACT: stay while blocked[b] = 1; when 0 → CMD.
- CMD:
  - cmd_valid = 1; cmd_bank, cmd_col and cmd_write are held stable until cmd_ready.
  - On handshake: CLOSE_PAGE = 0 → IDLE; CLOSE_PAGE = 1 → CLOSE.
- CLOSE: precharge[b] = 1 for one cycle → WAIT_CLOSE.
- WAIT_CLOSE: when blocked[b] = 0 → IDLE.
- Timing and counter rules:
  - row_address = 0 whenever activate is all zero.
  - Best-case hit latency: accept edge → CHECK → CMD, so cmd_valid is asserted 2 cycles after acceptance.
  - Counters saturate at all-ones, never wrap. Exactly one counter increments per request, at CHECK exit.
  - Pulses for banks other than b are always 0; precharge and activate are never high in the same cycle.
- Boundary conditions:
  - cmd_ready held 0 indefinitely: remain in CMD with outputs stable.
  - Tracker blocked stuck high: remain in the wait state; no timeout.
  - A request targeting a blocked bank is accepted but waits in CHECK; no pulse is issued until blocked = 0.
  - rst concurrent with req_valid: request not accepted.

Test Plan:
- Empty bank: rst, then request bank 3, row 0x1A2, col 5, read, with the tracker model (ACT latency 8, PRE 5) → activate = 8'b0000_1000 with row_address 0x1A2 for 1 cycle; cmd_valid after blocked[3] falls; cmd_col = 5; empty_count = 1.
- Hit: repeat bank 3, row 0x1A2, col 9, write, with cmd_ready = 1 → no pulse; cmd_valid 2 cycles after acceptance; hit_count = 1.
- Miss: bank 3, row 0x0F0 → precharge[3] pulse, then activate[3] with row 0x0F0 only after blocked[3] deasserts, then cmd; miss_count = 1; total pulses 2.
- Backpressure and blocked start: hold cmd_ready = 0 for 10 cycles → cmd fields stable, req_ready = 0. Next request to a bank with blocked forced high → no pulse until release.
- CLOSE_PAGE = 1: single read to bank 0 → activate, cmd, then precharge[0] pulse; req_ready returns only after blocked[0] clears.
- Reset mid-WAIT_ACT and counter saturation: rst → all outputs 0, req_ready = 1. With STAT_W = 2, 5 hits → hit_count = 3.
